// File: rtl/mseq_gen.sv
// Maximal-length LFSR generator with runtime seed/taps, frame reload and zero-lock recovery.
// Define MSEQ_PACK_EN to build the MSB-first byte packer; otherwise data/data_valid are tied low.
module mseq_gen #(
  parameter int unsigned      WIDTH     = 5,
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(5'b10101),
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(5'b11101),
  parameter int unsigned      FRAME_LEN = 32
) (
  input  logic             CLK_50MHZ,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [WIDTH-1:0] taps_in,
  output logic             out_fun,
  output logic [WIDTH-1:0] state,
  output logic             frame_start,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             lock_err,
  output logic             sclk
);

  localparam int unsigned FCNT_W    = (FRAME_LEN == 0) ? 1 : $clog2(FRAME_LEN + 1);
  localparam int unsigned FCNT_LAST = (FRAME_LEN == 0) ? 0 : FRAME_LEN - 1;
  localparam bit          RELOAD_EN = (FRAME_LEN != 0);

  logic [WIDTH-1:0]  state_q, state_d;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [WIDTH-1:0]  taps_q, taps_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              fs_q, fs_d;
  logic              lock_q, lock_d;
  logic              fb_c;
  logic              frame_end_c;

  assign fb_c        = ^(state_q & taps_q);
  assign frame_end_c = RELOAD_EN && (fcnt_q == FCNT_W'(FCNT_LAST));

  // Priority: load > lock recovery > frame reload > shift > hold
  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    taps_d  = taps_q;
    fcnt_d  = fcnt_q;
    fs_d    = 1'b0;
    lock_d  = lock_q;
    if (load) begin
      seed_d  = seed_in;
      taps_d  = taps_in;
      state_d = seed_in;
      fcnt_d  = '0;
      lock_d  = 1'b0;
    end else if (en) begin
      if (state_q == '0) begin
        state_d = SEED;
        lock_d  = 1'b1;
      end else if (frame_end_c) begin
        state_d = seed_q;
        fcnt_d  = '0;
        fs_d    = 1'b1;
      end else begin
        state_d = {state_q[WIDTH-2:0], fb_c};
        fcnt_d  = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      state_q <= SEED;
      seed_q  <= SEED;
      taps_q  <= TAPS;
      fcnt_q  <= '0;
      fs_q    <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      taps_q  <= taps_d;
      fcnt_q  <= fcnt_d;
      fs_q    <= fs_d;
      lock_q  <= lock_d;
    end
  end

  assign state       = state_q;
  assign out_fun     = state_q[WIDTH-1];
  assign frame_start = fs_q;
  assign lock_err    = lock_q;
  assign sclk        = CLK_50MHZ;

`ifdef MSEQ_PACK_EN
  // Only the 7 newest bits are kept; the byte completes with the live out_fun bit.
  logic [6:0] sh_q, sh_d;
  logic [7:0] data_q, data_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       dv_q, dv_d;
  logic       take_c;
  logic       restart_c;

  assign take_c    = !load && en && (state_q != '0);
  assign restart_c = load || (take_c && frame_end_c);

  always_comb begin
    sh_d   = sh_q;
    data_d = data_q;
    bcnt_d = bcnt_q;
    dv_d   = 1'b0;
    if (take_c) begin
      sh_d   = {sh_q[5:0], out_fun};
      bcnt_d = bcnt_q + 3'd1;
      if (bcnt_q == 3'd7) begin
        data_d = {sh_q, out_fun};
        dv_d   = 1'b1;
      end
    end
    if (restart_c) begin
      bcnt_d = '0;
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (rst) begin
      sh_q   <= '0;
      data_q <= '0;
      bcnt_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      data_q <= data_d;
      bcnt_q <= bcnt_d;
      dv_q   <= dv_d;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
`else
  assign data       = 8'h00;
  assign data_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mseq_gen.sv
// Scoreboard bench for mseq_gen: stimulus queues expected per-cycle probes and packed bytes,
// a negedge monitor pops and compares them as the DUT presents outputs.
module tb_mseq_gen;

`ifdef MSEQ_PACK_EN
  localparam bit PACK = 1'b1;
`else
  localparam bit PACK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [4:0] seed_in, taps_in;
  logic       out_fun, frame_start, data_valid, lock_err, sclk;
  logic [4:0] state;
  logic [7:0] data;

  always #5 clk = ~clk;

  mseq_gen dut (
    .CLK_50MHZ   (clk),
    .rst         (rst),
    .en          (en),
    .load        (load),
    .seed_in     (seed_in),
    .taps_in     (taps_in),
    .out_fun     (out_fun),
    .state       (state),
    .frame_start (frame_start),
    .data        (data),
    .data_valid  (data_valid),
    .lock_err    (lock_err),
    .sclk        (sclk)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [4:0] st;
    logic       fs;
    logic       lk;
    logic       dv;
    logic       dchk;
    logic [7:0] dat;
  } probe_t;

  probe_t     probe_q[$];
  logic [7:0] byte_q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  bit         done = 1'b0;
  bit         drained = 1'b0;
  logic       sclk_hi = 1'b0;
  logic       dchk_next = 1'b0;
  logic [7:0] dat_next = 8'h00;

  // Hand-computed: seed 10101, taps 10100, states after each of 8 shifts
  logic [4:0] pk_tbl [8] = '{5'h0A, 5'h14, 5'h08, 5'h10, 5'h01, 5'h02, 5'h04, 5'h09};
  // Hand-computed: seed 00001, taps 10100, 31-step period then reload on shift 32
  logic [4:0] fr_tbl [32] = '{5'h02, 5'h04, 5'h09, 5'h12, 5'h05, 5'h0B, 5'h16, 5'h0C,
                              5'h19, 5'h13, 5'h07, 5'h0F, 5'h1F, 5'h1E, 5'h1C, 5'h18,
                              5'h11, 5'h03, 5'h06, 5'h0D, 5'h1B, 5'h17, 5'h0E, 5'h1D,
                              5'h1A, 5'h15, 5'h0A, 5'h14, 5'h08, 5'h10, 5'h01, 5'h01};
  logic [7:0] fr_bytes [4] = '{8'h09, 8'h67, 8'hC6, 8'hEA};
  // Hand-computed: after reset, seed 10101 with default taps 11101
  logic [4:0] rs_tbl [11] = '{5'h0B, 5'h16, 5'h0C, 5'h18, 5'h10, 5'h01, 5'h03, 5'h07,
                              5'h0E, 5'h1C, 5'h19};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    sclk_hi = sclk;
  end

  task automatic want_data(input logic [7:0] d);
    dchk_next = 1'b1;
    dat_next  = d;
  endtask

  task automatic go(input logic r, input logic e, input logic l,
                    input logic [4:0] s, input logic [4:0] t, input string nm,
                    input logic [4:0] st, input logic fs, input logic lk, input logic dv);
    probe_t p;
    p.cyc  = cyc + 1;
    p.nm   = nm;
    p.st   = st;
    p.fs   = fs;
    p.lk   = lk;
    p.dv   = dv & PACK;
    p.dchk = dchk_next;
    p.dat  = dat_next;
    dchk_next = 1'b0;
    probe_q.push_back(p);
    rst = r; en = e; load = l; seed_in = s; taps_in = t;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input string tag);
    for (int k = 0; k < 32; k++) begin
      if ((k % 8) == 7 && PACK) byte_q.push_back(fr_bytes[k / 8]);
      go(1'b0, 1'b1, 1'b0, 5'h00, 5'h00, $sformatf("%s%0d", tag, k),
         fr_tbl[k], (k == 31), 1'b0, ((k % 8) == 7));
    end
  endtask

  // Monitor: compare packed bytes on data_valid and per-cycle probes when due
  always @(negedge clk) begin
    probe_t     p;
    logic [7:0] b;
    logic [10:0] act, req;
    if (data_valid === 1'b1) begin
      n_chk++;
      if (byte_q.size() == 0) begin
        $display("FAIL unexpected_valid: data_valid=1 data=%h, required no byte pending", data);
      end else begin
        b = byte_q.pop_front();
        if (data !== b) $display("FAIL packed_byte: data=%h, required %h", data, b);
        else n_pass++;
      end
    end
    while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
      p = probe_q.pop_front();
      n_chk++;
      act = {state, out_fun, frame_start, lock_err, data_valid, sclk_hi, sclk};
      req = {p.st, p.st[4], p.fs, p.lk, p.dv, 1'b1, 1'b0};
      if (act !== req)
        $display("FAIL %s: state=%h out=%b fs=%b lock=%b dv=%b sclk=%b%b, required state=%h out=%b fs=%b lock=%b dv=%b sclk=10",
                 p.nm, state, out_fun, frame_start, lock_err, data_valid, sclk_hi, sclk,
                 p.st, p.st[4], p.fs, p.lk, p.dv);
      else n_pass++;
      if (p.dchk) begin
        n_chk++;
        if (data !== p.dat) $display("FAIL %s_data: data=%h, required %h", p.nm, data, p.dat);
        else n_pass++;
      end
    end
    if (done && !drained) begin
      drained = 1'b1;
      n_chk++;
      if (byte_q.size() != 0 || probe_q.size() != 0)
        $display("FAIL drain: bytes left=%0d probes left=%0d, required 0 and 0",
                 byte_q.size(), probe_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; seed_in = 5'h00; taps_in = 5'h00;
    want_data(8'h00);
    go(1'b1, 1'b0, 1'b0, 5'h00, 5'h00, "reset", 5'h15, 1'b0, 1'b0, 1'b0);

    // Byte packing: out_fun 1,0,1,0,1,0,0,0 -> 8'hA8
    go(1'b0, 1'b0, 1'b1, 5'h15, 5'h14, "load", 5'h15, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) begin
        if (PACK) byte_q.push_back(8'hA8);
        want_data(PACK ? 8'hA8 : 8'h00);
      end
      go(1'b0, 1'b1, 1'b0, 5'h00, 5'h00, $sformatf("pack%0d", k), pk_tbl[k], 1'b0, 1'b0, (k == 7));
    end
    go(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, "gap0", 5'h09, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, "gap1", 5'h09, 1'b0, 1'b0, 1'b0);

    // Full period and two frame reloads
    go(1'b0, 1'b0, 1'b1, 5'h01, 5'h14, "load_fr", 5'h01, 1'b0, 1'b0, 1'b0);
    run_frame("fra");
    run_frame("frb");

    // Lock recovery, stickiness, and clear on load
    go(1'b0, 1'b0, 1'b1, 5'h00, 5'h14, "lock_load", 5'h00, 1'b0, 1'b0, 1'b0);
    go(1'b0, 1'b1, 1'b0, 5'h00, 5'h00, "lock_rec", 5'h15, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b1, 1'b0, 5'h00, 5'h00, "lock_sticky", 5'h0A, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b0, 5'h00, 5'h00, "lock_hold", 5'h0A, 1'b0, 1'b1, 1'b0);
    go(1'b0, 1'b0, 1'b1, 5'h01, 5'h14, "lock_clear", 5'h01, 1'b0, 1'b0, 1'b0);

    // Reset mid-byte, then next byte only after 8 fresh shifts
    for (int k = 0; k < 5; k++)
      go(1'b0, 1'b1, 1'b0, 5'h00, 5'h00, $sformatf("mid%0d", k), fr_tbl[k], 1'b0, 1'b0, 1'b0);
    want_data(8'h00);
    go(1'b1, 1'b1, 1'b0, 5'h00, 5'h00, "rst_mid", 5'h15, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++) begin
      if (k == 7 && PACK) byte_q.push_back(8'hAC);
      go(1'b0, 1'b1, 1'b0, 5'h00, 5'h00, $sformatf("post%0d", k), rs_tbl[k], 1'b0, 1'b0, (k == 7));
    end

    // load + en together: load wins, frame and byte counters restart cleanly
    go(1'b0, 1'b1, 1'b1, 5'h01, 5'h14, "prio", 5'h01, 1'b0, 1'b0, 1'b0);
    run_frame("frc");

    en = 1'b0;
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
